// File: rtl/fifo_drain_checker_pkg.sv
// Shared types and constants for the FIFO drain checker: FSM encodings,
// read-strobe polarity, datapath widths and the wait-counter load helper.
package fifo_drain_checker_pkg;

  localparam int DATA_W        = 32;
  localparam int ERR_W_DEFAULT = 16;

  // Wait counter only has to hold RD_LATENCY-1, and RD_LATENCY tops out at 3.
  localparam int WAIT_W        = 2;

  // The FIFO read strobe is active-low.
  localparam logic RDEN_ACTIVE = 1'b0;
  localparam logic RDEN_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAP     = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  // Value loaded into the wait counter as the read strobe is released.
  // Leaving S_WAIT happens when the counter steps from 1 down to 0.
  function automatic logic [WAIT_W-1:0] wait_load(input int rd_latency);
    return WAIT_W'(rd_latency - 1);
  endfunction

endpackage

// File: rtl/fifo_drain_checker_seq_checker.sv
// Sequence checker: each captured word must be the previous word + 1
// (mod 2^32). Owns the expected value, the synced flag and the word/error
// counters. A mismatch resyncs to the received word, so a single dropped
// sample costs exactly one error.
module fifo_drain_checker_seq_checker
  import fifo_drain_checker_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic              CAP,
  input  logic [DATA_W-1:0] WORD,
  output logic [DATA_W-1:0] WORDCOUNT,
  output logic [ERR_W-1:0]  ERRCOUNT,
  output logic              ERR
);

  logic [DATA_W-1:0] expected_q;
  logic              synced_q;
  logic [DATA_W-1:0] wordcount_q;
  logic [ERR_W-1:0]  errcount_q;
  logic              err_q;
  logic              mismatch;
  logic              errcount_full;

  // The first word after reset or CLEAR only seeds the expected value.
  assign mismatch      = synced_q && (WORD != expected_q);
  assign errcount_full = (errcount_q == {ERR_W{1'b1}});

  // Expected-value tracking and counters; CLEAR beats a coincident capture
  // but the captured word still becomes the new expected base.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      expected_q  <= '0;
      synced_q    <= 1'b0;
      wordcount_q <= '0;
      errcount_q  <= '0;
      err_q       <= 1'b0;
    end else if (CLEAR) begin
      wordcount_q <= '0;
      errcount_q  <= '0;
      err_q       <= 1'b0;
      if (CAP) begin
        expected_q <= WORD + DATA_W'(1);
        synced_q   <= 1'b1;
      end else begin
        synced_q   <= 1'b0;
      end
    end else if (CAP) begin
      expected_q  <= WORD + DATA_W'(1);
      synced_q    <= 1'b1;
      wordcount_q <= wordcount_q + DATA_W'(1);
      if (mismatch) begin
        err_q <= 1'b1;
        if (!errcount_full) begin
          errcount_q <= errcount_q + ERR_W'(1);
        end
      end
    end
  end

  assign WORDCOUNT = wordcount_q;
  assign ERRCOUNT  = errcount_q;
  assign ERR       = err_q;

endmodule

// File: rtl/fifo_drain_checker.sv
// FIFO drain checker top: pops one 32-bit word at a time with an active-low
// read strobe, waits out the FIFO read latency, captures the word, checks it
// for +1 continuity and presents it downstream over valid/ready.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | nothing outstanding; pop as soon as the FIFO is non-empty
// S_READ    | READEN low for this single cycle; arm the latency counter
// S_WAIT    | count down the remaining FIFO read latency
// S_CAP     | RDATA valid: register it, raise DVALID, run the check
// S_PRESENT | hold DOUT/DVALID until DREADY; chain the next pop if possible
module fifo_drain_checker
  import fifo_drain_checker_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ERR_W      = ERR_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EMPTY,
  input  logic [DATA_W-1:0] RDATA,
  output logic              READEN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  input  logic              CLEAR,
  output logic [DATA_W-1:0] WORDCOUNT,
  output logic [ERR_W-1:0]  ERRCOUNT,
  output logic              ERR
);

  state_t            state_q,  state_d;
  logic [WAIT_W-1:0] wait_q,   wait_d;
  logic              readen_q, readen_d;
  logic [DATA_W-1:0] dout_q,   dout_d;
  logic              dvalid_q, dvalid_d;
  logic              cap_stb;

  // State register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      readen_q <= RDEN_IDLE;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      readen_q <= readen_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Next-state and next-output decode. EMPTY is only looked at in S_IDLE
  // and S_PRESENT, which keeps a single read in flight and guarantees the
  // strobe never drops while the FIFO reported empty.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    readen_d = readen_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    cap_stb  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!EMPTY) begin
          readen_d = RDEN_ACTIVE;
          state_d  = S_READ;
        end
      end

      S_READ: begin
        readen_d = RDEN_IDLE;
        wait_d   = wait_load(RD_LATENCY);
        state_d  = (RD_LATENCY == 1) ? S_CAP : S_WAIT;
      end

      S_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q == WAIT_W'(1)) begin
          state_d = S_CAP;
        end
      end

      S_CAP: begin
        dout_d   = RDATA;
        dvalid_d = 1'b1;
        cap_stb  = 1'b1;
        state_d  = S_PRESENT;
      end

      S_PRESENT: begin
        if (DREADY) begin
          dvalid_d = 1'b0;
          if (!EMPTY) begin
            readen_d = RDEN_ACTIVE;
            state_d  = S_READ;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        readen_d = RDEN_IDLE;
        dvalid_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  fifo_drain_checker_seq_checker #(
    .ERR_W (ERR_W)
  ) u_seq_checker (
    .CLK       (CLK),
    .RESET     (RESET),
    .CLEAR     (CLEAR),
    .CAP       (cap_stb),
    .WORD      (RDATA),
    .WORDCOUNT (WORDCOUNT),
    .ERRCOUNT  (ERRCOUNT),
    .ERR       (ERR)
  );

  assign READEN = readen_q;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Bench for fifo_drain_checker: two instances (read latency 1 and 3), each
// fed by a behavioural FIFO. Words pushed into a FIFO also push the expected
// DOUT/counter values to a scoreboard that is popped on each handshake.
module tb_fifo_drain_checker;

  typedef struct {
    logic [31:0] w;
    logic [31:0] wc;
    logic [15:0] ec;
    logic        err;
  } item_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic CLEAR = 1'b0;
  always #5 CLK = ~CLK;

  // instance 0: RD_LATENCY = 1
  logic        empty0 = 1'b1;
  logic [31:0] rdata0 = '0;
  logic        rd0, dv0, err0;
  logic        dr0 = 1'b1;
  logic [31:0] dout0, wc0;
  logic [15:0] ec0;

  // instance 1: RD_LATENCY = 3
  logic        empty1 = 1'b1;
  logic [31:0] rdata1 = '0, p0_1 = '0, p1_1 = '0;
  logic        rd1, dv1, err1;
  logic        dr1 = 1'b1;
  logic [31:0] dout1, wc1;
  logic [15:0] ec1;

  int total = 0;
  int bad   = 0;

  logic [31:0] fq0[$], fq1[$];
  item_t       sb0[$], sb1[$];
  int          rdt0[$];
  int          cyc0 = 0, cyc1 = 0, rdn1 = 0, cyc_empty1 = 0, cyc_dv1 = 0;

  logic        m_sync[2];
  logic [31:0] m_exp[2], m_wc[2];
  logic [15:0] m_ec[2];
  logic        m_err[2];

  fifo_drain_checker #(.RD_LATENCY(1), .ERR_W(16)) dut_l1 (
    .CLK(CLK), .RESET(RESET), .EMPTY(empty0), .RDATA(rdata0), .READEN(rd0),
    .DOUT(dout0), .DVALID(dv0), .DREADY(dr0), .CLEAR(CLEAR),
    .WORDCOUNT(wc0), .ERRCOUNT(ec0), .ERR(err0)
  );

  fifo_drain_checker #(.RD_LATENCY(3), .ERR_W(16)) dut_l3 (
    .CLK(CLK), .RESET(RESET), .EMPTY(empty1), .RDATA(rdata1), .READEN(rd1),
    .DOUT(dout1), .DVALID(dv1), .DREADY(dr1), .CLEAR(CLEAR),
    .WORDCOUNT(wc1), .ERRCOUNT(ec1), .ERR(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFOs: pop on a sampled READEN=0, data after RD_LATENCY edges.
  always @(posedge CLK) begin
    if (rd0 === 1'b0 && fq0.size() > 0) rdata0 <= fq0.pop_front();
    empty0 <= (fq0.size() == 0);
  end

  always @(posedge CLK) begin
    if (rd1 === 1'b0 && fq1.size() > 0) p0_1 <= fq1.pop_front();
    p1_1   <= p0_1;
    rdata1 <= p1_1;
    empty1 <= (fq1.size() == 0);
  end

  // Monitor for instance 0: strobe shape, underflow, hold stability, scoreboard.
  logic        prev_rd0 = 1'b1, prev_dv0 = 1'b0, prev_dr0 = 1'b1;
  logic [31:0] prev_dout0 = '0;
  always @(negedge CLK) begin
    item_t it;
    cyc0 <= cyc0 + 1;
    if (rd0 === 1'b0) begin
      chk("l1_readen_width", 32'(prev_rd0), 32'd1);
      chk("l1_underflow", 32'(empty0), 32'd0);
      rdt0.push_back(cyc0);
    end
    if (prev_dv0 === 1'b1 && prev_dr0 === 1'b0) begin
      chk("l1_dvalid_hold", 32'(dv0), 32'd1);
      chk("l1_dout_hold", dout0, prev_dout0);
    end
    if (dv0 === 1'b1 && dr0 === 1'b1) begin
      if (sb0.size() == 0) begin
        chk("l1_unexpected_word", 32'(sb0.size()), 32'd1);
      end else begin
        it = sb0.pop_front();
        chk("l1_dout", dout0, it.w);
        chk("l1_wordcount", wc0, it.wc);
        chk("l1_errcount", 32'(ec0), 32'(it.ec));
        chk("l1_err", 32'(err0), 32'(it.err));
      end
    end
    prev_rd0   <= rd0;
    prev_dv0   <= dv0;
    prev_dr0   <= dr0;
    prev_dout0 <= dout0;
  end

  // Monitor for instance 1: underflow, latency markers, scoreboard.
  logic prev_rd1 = 1'b1, prev_dv1 = 1'b0, prev_empty1 = 1'b1;
  always @(negedge CLK) begin
    item_t it;
    cyc1 <= cyc1 + 1;
    if (rd1 === 1'b0) begin
      chk("l3_readen_width", 32'(prev_rd1), 32'd1);
      chk("l3_underflow", 32'(empty1), 32'd0);
      rdn1 <= rdn1 + 1;
    end
    if (empty1 === 1'b0 && prev_empty1 === 1'b1) cyc_empty1 <= cyc1;
    if (dv1 === 1'b1 && prev_dv1 === 1'b0) cyc_dv1 <= cyc1;
    if (dv1 === 1'b1 && dr1 === 1'b1) begin
      if (sb1.size() == 0) begin
        chk("l3_unexpected_word", 32'(sb1.size()), 32'd1);
      end else begin
        it = sb1.pop_front();
        chk("l3_dout", dout1, it.w);
        chk("l3_wordcount", wc1, it.wc);
        chk("l3_errcount", 32'(ec1), 32'(it.ec));
        chk("l3_err", 32'(err1), 32'(it.err));
      end
    end
    prev_rd1    <= rd1;
    prev_dv1    <= dv1;
    prev_empty1 <= empty1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset(input int i);
    m_sync[i] = 1'b0;
    m_exp[i]  = '0;
    m_wc[i]   = '0;
    m_ec[i]   = '0;
    m_err[i]  = 1'b0;
  endtask

  task automatic push_raw(input int i, input logic [31:0] w, input logic [31:0] wc,
                          input logic [15:0] ec, input logic err);
    item_t it;
    it.w = w; it.wc = wc; it.ec = ec; it.err = err;
    if (i == 0) begin fq0.push_back(w); sb0.push_back(it); end
    else        begin fq1.push_back(w); sb1.push_back(it); end
  endtask

  // Reference behaviour of the continuity check, applied at push time.
  task automatic push_word(input int i, input logic [31:0] w);
    if (m_sync[i] && w != m_exp[i]) begin
      if (m_ec[i] != 16'hFFFF) m_ec[i] = m_ec[i] + 16'd1;
      m_err[i] = 1'b1;
    end
    m_sync[i] = 1'b1;
    m_exp[i]  = w + 32'd1;
    m_wc[i]   = m_wc[i] + 32'd1;
    push_raw(i, w, m_wc[i], m_ec[i], m_err[i]);
  endtask

  task automatic pulse_clear();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    model_reset(0);
    model_reset(1);
  endtask

  function automatic bit is_idle(input int i);
    if (i == 0) return fq0.size() == 0 && sb0.size() == 0 && dv0 === 1'b0 && rd0 === 1'b1;
    return fq1.size() == 0 && sb1.size() == 0 && dv1 === 1'b0 && rd1 === 1'b1;
  endfunction

  task automatic wait_idle(input int i, input int max);
    int n;
    n = 0;
    @(negedge CLK);
    while (!is_idle(i) && n < max) begin @(negedge CLK); n++; end
    chk($sformatf("idle_timeout_%0d", i), 32'(n < max), 32'd1);
    step();
  endtask

  task automatic wait_rd_low(input int i, input int max);
    int n;
    n = 0;
    @(negedge CLK);
    while (((i == 0) ? rd0 : rd1) !== 1'b0 && n < max) begin @(negedge CLK); n++; end
    chk($sformatf("readen_timeout_%0d", i), 32'(n < max), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset(0);
    model_reset(1);

    // reset values
    RESET = 1'b1;
    step(); step();
    @(negedge CLK);
    chk("rst_readen", 32'(rd0), 32'd1);
    chk("rst_dvalid", 32'(dv0), 32'd0);
    chk("rst_dout", dout0, 32'd0);
    chk("rst_wordcount", wc0, 32'd0);
    chk("rst_errcount", 32'(ec0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_l3_readen", 32'(rd1), 32'd1);
    chk("rst_l3_dvalid", 32'(dv1), 32'd0);
    step();
    RESET = 1'b0;

    // clean incrementing run, DREADY high: one pop every 3 clocks
    push_word(0, 32'd5); push_word(0, 32'd6); push_word(0, 32'd7); push_word(0, 32'd8);
    wait_idle(0, 200);
    chk("t1_pulses", 32'(rdt0.size()), 32'd4);
    for (int k = 1; k < rdt0.size(); k++) chk("t1_spacing", 32'(rdt0[k] - rdt0[k-1]), 32'd3);
    chk("t1_wordcount", wc0, 32'd4);
    chk("t1_errcount", 32'(ec0), 32'd0);
    chk("t1_err", 32'(err0), 32'd0);

    // one skipped value costs one error
    pulse_clear();
    push_word(0, 32'd10); push_word(0, 32'd11); push_word(0, 32'd13); push_word(0, 32'd14);
    wait_idle(0, 200);
    chk("t2_wordcount", wc0, 32'd4);
    chk("t2_errcount", 32'(ec0), 32'd1);
    chk("t2_err", 32'(err0), 32'd1);

    // CLEAR coincident with capture of 20: counters zero, 20 becomes the base
    push_raw(0, 32'd20, 32'd0, 16'd0, 1'b0);
    m_sync[0] = 1'b1; m_exp[0] = 32'd21; m_wc[0] = '0; m_ec[0] = '0; m_err[0] = 1'b0;
    push_word(0, 32'd21);
    wait_rd_low(0, 50);
    step();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    model_reset(1);
    wait_idle(0, 200);
    chk("t3_wordcount", wc0, 32'd1);
    chk("t3_errcount", 32'(ec0), 32'd0);
    chk("t3_err", 32'(err0), 32'd0);

    // wrap from all-ones to zero is legal
    pulse_clear();
    push_word(0, 32'hFFFF_FFFE); push_word(0, 32'hFFFF_FFFF); push_word(0, 32'h0000_0000);
    wait_idle(0, 200);
    chk("t4_wordcount", wc0, 32'd3);
    chk("t4_errcount", 32'(ec0), 32'd0);
    chk("t4_err", 32'(err0), 32'd0);

    // consumer stalls for 10 cycles with more data waiting
    pulse_clear();
    dr0 = 1'b0;
    push_word(0, 32'd30); push_word(0, 32'd31);
    n = 0;
    @(negedge CLK);
    while (dv0 !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    chk("t5_dvalid_timeout", 32'(n < 50), 32'd1);
    repeat (10) begin
      chk("t5_hold_dvalid", 32'(dv0), 32'd1);
      chk("t5_hold_dout", dout0, 32'd30);
      chk("t5_hold_readen", 32'(rd0), 32'd1);
      @(negedge CLK);
    end
    step();
    dr0 = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_next_readen", 32'(rd0), 32'd0);
    chk("t5_dvalid_drop", 32'(dv0), 32'd0);
    wait_idle(0, 200);
    chk("t5_wordcount", wc0, 32'd2);

    // read latency 3: DVALID five cycles after EMPTY falls, single pop
    push_word(1, 32'd100);
    wait_idle(1, 200);
    chk("t6_latency", 32'(cyc_dv1 - cyc_empty1), 32'd5);
    chk("t6_pulses", 32'(rdn1), 32'd1);
    chk("t6_wordcount", wc1, 32'd1);

    // reset while waiting on the FIFO: popped word is lost, checker resyncs
    fq1.push_back(32'd200);
    wait_rd_low(1, 50);
    step();
    RESET = 1'b1;
    step();
    @(negedge CLK);
    chk("t7_readen", 32'(rd1), 32'd1);
    chk("t7_dvalid", 32'(dv1), 32'd0);
    chk("t7_wordcount", wc1, 32'd0);
    step();
    RESET = 1'b0;
    model_reset(0);
    model_reset(1);
    push_word(1, 32'd201);
    wait_idle(1, 200);
    chk("t7_after_wordcount", wc1, 32'd1);
    chk("t7_after_errcount", 32'(ec1), 32'd0);
    chk("t7_after_err", 32'(err1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
